phase_from_iq: RTL and testbench

Iterative CORDIC vectoring engine; inverse of the quarter-wave sine lookup. Takes a Q14 (cos, sin) pair and returns the 10-bit phase (0–1023 = 0 to 2π) in the sine LUT's phase convention, plus the vector magnitude in Q14. Used by the energy landscape and oscillator monitors to recover oscillator phase from sampled I/Q outputs. Uses a valid/ready handshake on both sides, with one operation in flight.

---
 rtl/phase_from_iq_if.sv | 24 ++
 rtl/phase_from_iq.sv | 183 ++++++++++++++++++
 tb/tb_phase_from_iq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/phase_from_iq_if.sv
// Handshake bundle for phase_from_iq: I/Q request channel plus phase/magnitude result channel.
interface phase_from_iq_if #(
    parameter int WIDTH = 18
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] cos_in;
    logic signed [WIDTH-1:0] sin_in;
    logic                    out_valid;
    logic                    out_ready;
    logic        [9:0]       phase_out;
    logic signed [WIDTH-1:0] mag_out;
    logic                    zero_flag;

    modport master (
        output in_valid, cos_in, sin_in, out_ready,
        input  in_ready, out_valid, phase_out, mag_out, zero_flag
    );

    modport slave (
        input  in_valid, cos_in, sin_in, out_ready,
        output in_ready, out_valid, phase_out, mag_out, zero_flag
    );
endinterface

// File: rtl/phase_from_iq.sv
// Iterative CORDIC vectoring engine: recovers the 10-bit phase (1024 = 2*pi) and the
// gain-corrected Q14 magnitude of a signed (cos, sin) pair, one operation in flight.
module phase_from_iq #(
    parameter int WIDTH      = 18,
    parameter int FRAC       = 14,
    parameter int ITERATIONS = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    phase_from_iq_if.slave   bus
);
    localparam int XW = WIDTH + 2;
    localparam int PW = XW + 16;
    localparam logic        [3:0]    LAST    = 4'(ITERATIONS - 1);
    localparam logic signed [PW-1:0] INV_K   = PW'(9949);
    localparam logic signed [PW-1:0] HALF    = PW'(1 << (FRAC - 1));
    localparam logic signed [PW-1:0] MAG_MAX = PW'((1 << WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [XW-1:0]   x_q, x_d;
    logic signed [XW-1:0]   y_q, y_d;
    logic        [15:0]     z_q, z_d;
    logic        [3:0]      cnt_q, cnt_d;
    logic                   zin_q, zin_d;
    logic        [9:0]      phase_q, phase_d;
    logic        [WIDTH-1:0] mag_q, mag_d;
    logic                   zero_q, zero_d;

    logic signed [XW-1:0]   cos_ext;
    logic signed [XW-1:0]   sin_ext;
    logic signed [XW-1:0]   x_sh;
    logic signed [XW-1:0]   y_sh;
    logic signed [PW-1:0]   prod;

    function automatic logic [15:0] atan_lut(input logic [3:0] i);
        logic [15:0] a;
        case (i)
            4'd0:    a = 16'd8192;
            4'd1:    a = 16'd4836;
            4'd2:    a = 16'd2555;
            4'd3:    a = 16'd1297;
            4'd4:    a = 16'd651;
            4'd5:    a = 16'd326;
            4'd6:    a = 16'd163;
            4'd7:    a = 16'd81;
            4'd8:    a = 16'd41;
            4'd9:    a = 16'd20;
            4'd10:   a = 16'd10;
            4'd11:   a = 16'd5;
            4'd12:   a = 16'd3;
            4'd13:   a = 16'd1;
            default: a = 16'd0;
        endcase
        return a;
    endfunction

    // Half-up rounding of the 16-bit angle to 10 bits; the add wraps so 1023.5+ lands on 0.
    function automatic logic [9:0] round_phase(input logic [15:0] z);
        return 10'((z + 16'd32) >> 6);
    endfunction

    function automatic logic [WIDTH-1:0] round_sat_mag(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] r;
        logic        [WIDTH-1:0] m;
        r = (p + HALF) >>> FRAC;
        if (r[PW-1])
            m = '0;
        else if (r > MAG_MAX)
            m = '1;
        else
            m = r[WIDTH-1:0];
        return m;
    endfunction

    // Two guard bits let -2^(WIDTH-1) negate and absorb the ~1.65x CORDIC growth.
    assign cos_ext = {{2{bus.cos_in[WIDTH-1]}}, bus.cos_in};
    assign sin_ext = {{2{bus.sin_in[WIDTH-1]}}, bus.sin_in};
    assign x_sh    = x_q >>> cnt_q;
    assign y_sh    = y_q >>> cnt_q;
    assign prod    = $signed({{(PW-XW){x_q[XW-1]}}, x_q}) * INV_K;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        zin_d   = zin_q;
        phase_d = phase_q;
        mag_d   = mag_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.cos_in[WIDTH-1]) begin
                        x_d = -cos_ext;
                        y_d = -sin_ext;
                        z_d = 16'd32768;
                    end else begin
                        x_d = cos_ext;
                        y_d = sin_ext;
                        z_d = 16'd0;
                    end
                    zin_d   = (bus.cos_in == '0) && (bus.sin_in == '0);
                    cnt_d   = 4'd0;
                    state_d = ITER;
                end
            end
            ITER: begin
                if (!y_q[XW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_lut(cnt_q);
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_lut(cnt_q);
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST)
                    state_d = SCALE;
            end
            SCALE: begin
                phase_d = zin_q ? 10'd0 : round_phase(z_q);
                mag_d   = zin_q ? '0 : round_sat_mag(prod);
                zero_d  = zin_q;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next state so they never glitch.
    assign in_ready_d  = (state_d == IDLE);
    assign out_valid_d = (state_d == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            cnt_q       <= '0;
            zin_q       <= 1'b0;
            phase_q     <= '0;
            mag_q       <= '0;
            zero_q      <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            cnt_q       <= cnt_d;
            zin_q       <= zin_d;
            phase_q     <= phase_d;
            mag_q       <= mag_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.phase_out = phase_q;
    assign bus.mag_out   = mag_q;
    assign bus.zero_flag = zero_q;
endmodule

// File: tb/tb_phase_from_iq.sv
// Bench for phase_from_iq: directed and random I/Q pairs checked against an atan2/sqrt model.
module tb_phase_from_iq;
    localparam int  WIDTH = 18;
    localparam real PI    = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    phase_from_iq_if #(.WIDTH(WIDTH)) bus ();

    phase_from_iq #(.WIDTH(WIDTH), .FRAC(14), .ITERATIONS(12)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic int ref_phase(input int c, input int s);
        real a;
        if (c == 0 && s == 0) return 0;
        a = $atan2(real'(s), real'(c));
        if (a < 0.0) a = a + 2.0 * PI;
        return int'($floor(a * 512.0 / PI + 0.5)) % 1024;
    endfunction

    function automatic int ref_mag(input int c, input int s);
        return int'($sqrt(real'(c) * real'(c) + real'(s) * real'(s)));
    endfunction

    function automatic int mag_u();
        return int'($unsigned(bus.mag_out));
    endfunction

    task automatic chk(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp_v, input int tol);
        int d;
        d = obs - exp_v;
        if (d < 0) d = -d;
        vectors++;
        assert ((d <= tol) === 1'b1) else begin
            miscompares++;
            $error("FAIL %s: got %0d, expected %0d +/- %0d", tag, obs, exp_v, tol);
        end
    endtask

    task automatic chk_phase(input string tag, input int obs, input int exp_v, input int tol);
        int d;
        d = (((obs - exp_v) % 1024) + 1024) % 1024;
        if (d > 512) d = 1024 - d;
        vectors++;
        assert ((d <= tol) === 1'b1) else begin
            miscompares++;
            $error("FAIL %s: got %0d, expected %0d +/- %0d (mod 1024)", tag, obs, exp_v, tol);
        end
    endtask

    task automatic send(input int c, input int s);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_before_send", int'(bus.in_ready), 1);
        bus.cos_in   = WIDTH'(c);
        bus.sin_in   = WIDTH'(s);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input int c, input int s, input string tag,
                               input int ptol, input int mtol);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_latency"}, n, 13);
        chk_phase({tag, "_phase"}, int'(bus.phase_out), ref_phase(c, s), ptol);
        chk_tol({tag, "_mag"}, mag_u(), ref_mag(c, s), mtol);
        chk({tag, "_zero"}, int'(bus.zero_flag), (c == 0 && s == 0) ? 1 : 0);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("consume_out_valid", int'(bus.out_valid), 0);
        chk("consume_in_ready", int'(bus.in_ready), 1);
    endtask

    task automatic op(input int c, input int s, input string tag, input int ptol, input int mtol);
        send(c, s);
        wait_result(c, s, tag, ptol, mtol);
        consume();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, s, ph, mg, zf;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.cos_in    = '0;
        bus.sin_in    = '0;
        bus.out_ready = 1'b0;
        #23;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_phase", int'(bus.phase_out), 0);
        chk("rst_mag", mag_u(), 0);
        chk("rst_zero", int'(bus.zero_flag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", int'(bus.in_ready), 1);
        chk("post_rst_out_valid", int'(bus.out_valid), 0);

        // Cardinal points, diagonal and the wrap boundary near phase 0.
        op(16384, 0, "card0", 0, 3);
        op(0, 16384, "card256", 0, 3);
        op(-16384, 0, "card512", 0, 3);
        op(0, -16384, "card768", 0, 3);
        op(11585, 11585, "diag128", 1, 3);
        op(16384, -100, "wrap1023", 0, 3);
        op(16384, -50, "wrap_half", 1, 3);
        op(16384, -20, "wrap0", 0, 3);

        op(-131072, 0, "extreme_neg", 0, 8);
        op(0, 0, "zero", 0, 0);

        for (int p = 0; p < 1024; p++) begin
            c = int'($floor(16384.0 * $cos(2.0 * PI * real'(p) / 1024.0) + 0.5));
            s = int'($floor(16384.0 * $sin(2.0 * PI * real'(p) / 1024.0) + 0.5));
            send(c, s);
            wait_result(c, s, "roundtrip", 1, 8);
            chk_phase("roundtrip_index", int'(bus.phase_out), p, 1);
            consume();
        end

        for (int k = 0; k < 200; k++) begin
            do begin
                c = int'($urandom_range(184000)) - 92000;
                s = int'($urandom_range(184000)) - 92000;
            end while (((c < 0) ? -c : c) + ((s < 0) ? -s : s) < 4000);
            op(c, s, "rand", 1, 8 + ref_mag(c, s) / 16384);
        end

        // Backpressure: result held, new request ignored until after the output handshake.
        send(-9000, 5000);
        wait_result(-9000, 5000, "bp_first", 1, 8);
        ph = int'(bus.phase_out);
        mg = mag_u();
        zf = int'(bus.zero_flag);
        bus.cos_in   = WIDTH'(0);
        bus.sin_in   = WIDTH'(16384);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", int'(bus.out_valid), 1);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_phase_hold", int'(bus.phase_out), ph);
            chk("bp_mag_hold", mag_u(), mg);
            chk("bp_zero_hold", int'(bus.zero_flag), zf);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_release_out_valid", int'(bus.out_valid), 0);
        chk("bp_release_in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_accept_in_ready", int'(bus.in_ready), 0);
        wait_result(0, 16384, "bp_second", 0, 3);
        consume();

        // Reset during iteration 5 of an operation.
        send(13000, 7000);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_phase", int'(bus.phase_out), 0);
        chk("midrst_mag", mag_u(), 0);
        chk("midrst_zero", int'(bus.zero_flag), 0);
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("after_rst_out_valid", int'(bus.out_valid), 0);
            chk("after_rst_in_ready", int'(bus.in_ready), 1);
        end
        op(13000, 7000, "after_rst", 1, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
